ofs_serializer_tx: RTL



---
 rtl/ofs_pkg.sv | 9 +
 rtl/ofs_pad_reg.sv | 17 +
 rtl/ofs_serializer_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/ofs_pkg.sv
// Shared definitions for the output serializer: FSM encoding and default idle level.
package ofs_pkg;
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_VAL_DEF = 1'b1;
endpackage

// File: rtl/ofs_pad_reg.sv
// Single pad-side flop: async active-low reset to RST_VAL, async preset to 1 on pd.
module ofs_pad_reg #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pd,
  input  logic d,
  output logic q
);
  // Reset outranks the power-down preset.
  always_ff @(posedge clk or negedge rst_n or posedge pd) begin
    if (!rst_n)  q <= RST_VAL;
    else if (pd) q <= 1'b1;
    else         q <= d;
  end
endmodule

// File: rtl/ofs_serializer_tx.sv
// Parallel-to-serial pad driver: valid/ready word intake, one bit per SCLK on Q with OE.
module ofs_serializer_tx
  import ofs_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_VAL  = IDLE_VAL_DEF
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic             PD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             Q,
  output logic             OE,
  output logic             BUSY
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-2:0] shreg, shreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d, q_d, oe_d;
  logic             last, accept, first_bit, next_bit;
  logic [WIDTH-2:0] rest;

  assign last      = (cnt == CNT_LAST);
  assign DREADY    = RSTN && !PD && ((state == ST_IDLE) || ((state == ST_SHIFT) && last));
  assign accept    = DVALID && DREADY;
  assign first_bit = MSB_FIRST ? DIN[WIDTH-1] : DIN[0];
  assign rest      = MSB_FIRST ? DIN[WIDTH-2:0] : DIN[WIDTH-1:1];
  assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[0];

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (PD) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nx = ST_SHIFT;
        ST_SHIFT: if (last && !accept) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Accept reloads in place, so a word boundary never shows an idle bit.
  always_comb begin
    q_d     = Q;
    oe_d    = OE;
    busy_d  = BUSY;
    shreg_d = shreg;
    cnt_d   = cnt;
    if (PD) begin
      q_d     = IDLE_VAL;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      q_d     = first_bit;
      oe_d    = 1'b1;
      busy_d  = 1'b1;
      shreg_d = rest;
      cnt_d   = '0;
    end else if (state == ST_SHIFT && !last) begin
      q_d     = next_bit;
      shreg_d = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      cnt_d   = cnt + CNT_W'(1);
    end else if (state == ST_SHIFT) begin
      q_d     = IDLE_VAL;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      shreg <= '0;
      cnt   <= '0;
      BUSY  <= 1'b0;
    end else begin
      shreg <= shreg_d;
      cnt   <= cnt_d;
      BUSY  <= busy_d;
    end
  end

  ofs_pad_reg #(.RST_VAL(IDLE_VAL)) u_q_reg (
    .clk(SCLK), .rst_n(RSTN), .pd(PD), .d(q_d), .q(Q)
  );

  ofs_pad_reg #(.RST_VAL(1'b0)) u_oe_reg (
    .clk(SCLK), .rst_n(RSTN), .pd(1'b0), .d(oe_d), .q(OE)
  );
endmodule
